// File: rtl/shaft_plant_model.sv
// Elevator shaft and door plant: answers engine/door commands with floor and door sensors,
// tracks true car position and latches plant faults. Define PLANT_OBSTRUCT_EN for the obstruct input.
module shaft_plant_model #(
   parameter int NUM_FLOORS  = 8,
   parameter int FLOOR_TICKS = 16,
   parameter int TICK_DIV    = 64,
   parameter int DOOR_TICKS  = 32,
   parameter int INIT_FLOOR  = 0,
   parameter int INIT_OFFSET = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] engine,
   input  logic [1:0] door,
`ifdef PLANT_OBSTRUCT_EN
   input  logic       obstruct,
`endif
   output logic       sensor_up,
   output logic       sensor_down,
   output logic [1:0] sensor_door,
   output logic [3:0] car_floor,
   output logic       fault
);

   localparam int OW = $clog2(FLOOR_TICKS);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = $clog2(DOOR_TICKS + 1);

   typedef enum logic [1:0] {CAR_STOP, CAR_UP, CAR_DOWN} car_state_t;
   typedef enum logic [1:0] {DOOR_CLOSED, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING} door_state_t;

   car_state_t  car_state_q, car_next;
   door_state_t door_state_q, door_state_next;

   logic [3:0]    floor_q, floor_next;
   logic [OW-1:0] offset_q, offset_next;
   logic          dir_up_q, dir_up_next;
   logic [PW-1:0] step_cnt_q, step_cnt_next, step_cnt_cur;
   logic [DW-1:0] door_pos_q, door_pos_next;
   logic [PW-1:0] door_cnt_q, door_cnt_next, door_cnt_cur;
   logic [1:0]    door_cmd_q, door_cmd;
   logic          fault_q, car_fault, door_fault;
`ifdef PLANT_OBSTRUCT_EN
   logic          reverse_q, reverse_next;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         car_state_q  <= CAR_STOP;
         door_state_q <= DOOR_CLOSED;
         floor_q      <= 4'(INIT_FLOOR);
         offset_q     <= OW'(INIT_OFFSET);
         dir_up_q     <= 1'b0;
         step_cnt_q   <= '0;
         door_pos_q   <= '0;
         door_cnt_q   <= '0;
         door_cmd_q   <= 2'b00;
         fault_q      <= 1'b0;
`ifdef PLANT_OBSTRUCT_EN
         reverse_q    <= 1'b0;
`endif
      end else begin
         car_state_q  <= car_next;
         door_state_q <= door_state_next;
         floor_q      <= floor_next;
         offset_q     <= offset_next;
         dir_up_q     <= dir_up_next;
         step_cnt_q   <= step_cnt_next;
         door_pos_q   <= door_pos_next;
         door_cnt_q   <= door_cnt_next;
         door_cmd_q   <= door_cmd;
         fault_q      <= fault_q | car_fault | door_fault;
`ifdef PLANT_OBSTRUCT_EN
         reverse_q    <= reverse_next;
`endif
      end
   end

   // A new engine command restarts the step prescaler, so the first step lands TICK_DIV clocks later.
   always_comb begin
      car_next      = CAR_STOP;
      floor_next    = floor_q;
      offset_next   = offset_q;
      dir_up_next   = dir_up_q;
      step_cnt_next = '0;
      step_cnt_cur  = '0;
      car_fault     = 1'b0;
      case (engine)
         2'b01:   car_next = CAR_UP;
         2'b10:   car_next = CAR_DOWN;
         default: car_next = CAR_STOP;
      endcase
      if (engine == 2'b11) car_fault = 1'b1;
      if (engine != 2'b00 && door_pos_q != '0) car_fault = 1'b1;
      if (car_next != CAR_STOP) begin
         step_cnt_cur = (car_next == car_state_q) ? step_cnt_q : '0;
         if (step_cnt_cur == PW'(TICK_DIV - 1)) begin
            if (car_next == CAR_UP) begin
               if (floor_q == 4'(NUM_FLOORS - 1) && offset_q == '0) begin
                  car_fault = 1'b1;
               end else begin
                  dir_up_next = 1'b1;
                  if (offset_q == OW'(FLOOR_TICKS - 1)) begin
                     offset_next = '0;
                     floor_next  = floor_q + 1'b1;
                  end else begin
                     offset_next = offset_q + 1'b1;
                  end
               end
            end else begin
               if (floor_q == 4'd0 && offset_q == '0) begin
                  car_fault = 1'b1;
               end else begin
                  dir_up_next = 1'b0;
                  if (offset_q == '0) begin
                     offset_next = OW'(FLOOR_TICKS - 1);
                     floor_next  = floor_q - 1'b1;
                  end else begin
                     offset_next = offset_q - 1'b1;
                  end
               end
            end
         end else begin
            step_cnt_next = step_cnt_cur + 1'b1;
         end
      end
   end

   // Door commands are ignored (and faulted) while the car is between floor levels.
   always_comb begin
      door_fault    = (door == 2'b11) || (door != 2'b00 && offset_q != '0);
      door_cmd      = (door == 2'b11) ? 2'b00 : door;
`ifdef PLANT_OBSTRUCT_EN
      reverse_next = reverse_q;
      if (door_state_q == DOOR_CLOSING && obstruct) reverse_next = 1'b1;
      else if (reverse_q && !obstruct && door == 2'b10) reverse_next = 1'b0;
      if (reverse_next) door_cmd = 2'b01;
`endif
      if (offset_q != '0) door_cmd = 2'b00;
      door_pos_next = door_pos_q;
      door_cnt_next = '0;
      door_cnt_cur  = '0;
      if (door_cmd != 2'b00) begin
         door_cnt_cur = (door_cmd == door_cmd_q) ? door_cnt_q : '0;
         if (door_cnt_cur == PW'(TICK_DIV - 1)) begin
            if (door_cmd == 2'b01 && door_pos_q != DW'(DOOR_TICKS)) door_pos_next = door_pos_q + 1'b1;
            else if (door_cmd == 2'b10 && door_pos_q != '0) door_pos_next = door_pos_q - 1'b1;
         end else begin
            door_cnt_next = door_cnt_cur + 1'b1;
         end
      end
      if (door_pos_next == '0) door_state_next = DOOR_CLOSED;
      else if (door_pos_next == DW'(DOOR_TICKS)) door_state_next = DOOR_OPEN;
      else if (door_pos_next > door_pos_q) door_state_next = DOOR_OPENING;
      else if (door_pos_next < door_pos_q) door_state_next = DOOR_CLOSING;
      else door_state_next = door_state_q;
   end

   always_comb begin
      sensor_up   = (offset_q == '0) && dir_up_q;
      sensor_down = (offset_q == '0) && !dir_up_q;
      car_floor   = floor_q;
      fault       = fault_q;
      case (door_state_q)
         DOOR_CLOSED: sensor_door = 2'b10;
         DOOR_OPEN:   sensor_door = 2'b01;
         default:     sensor_door = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_shaft_plant_model.sv
// Table-driven bench for shaft_plant_model (default build) plus a half-floor instance
// that exercises the arrival-from-mid-floor and bottom overtravel sequence.
module tb_shaft_plant_model;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] engine = 2'b00, door = 2'b00;
   logic [1:0] eng_h = 2'b00, door_h = 2'b00;
   logic       sensor_up, sensor_down, fault;
   logic [1:0] sensor_door;
   logic [3:0] car_floor;
   logic       up_h, down_h, fault_h;
   logic [1:0] sdoor_h;
   logic [3:0] floor_h;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   shaft_plant_model dut (
      .clock(clock), .reset(reset), .engine(engine), .door(door),
      .sensor_up(sensor_up), .sensor_down(sensor_down), .sensor_door(sensor_door),
      .car_floor(car_floor), .fault(fault)
   );

   shaft_plant_model #(.INIT_OFFSET(8)) dut_half (
      .clock(clock), .reset(reset), .engine(eng_h), .door(door_h),
      .sensor_up(up_h), .sensor_down(down_h), .sensor_door(sdoor_h),
      .car_floor(floor_h), .fault(fault_h)
   );

   typedef struct {
      string      name;
      logic       rst;
      logic [1:0] eng;
      logic [1:0] dr;
      int         cycles;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string n, logic r, logic [1:0] e, logic [1:0] d, int c,
                               logic u, logic dn, logic [1:0] sd, logic [3:0] fl, logic f);
      vec_t v;
      v.name = n; v.rst = r; v.eng = e; v.dr = d; v.cycles = c;
      v.exp = {u, dn, sd, fl, f};
      return v;
   endfunction

   task automatic check_output(input string nm, input logic [8:0] act, input logic [8:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got up=%b down=%b door=%b floor=%0d fault=%b, want up=%b down=%b door=%b floor=%0d fault=%b",
                  nm, act[8], act[7], act[6:5], act[4:1], act[0], exp[8], exp[7], exp[6:5], exp[4:1], exp[0]);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      reset  = v.rst;
      engine = v.eng;
      door   = v.dr;
      repeat (v.cycles) @(posedge clock);
      #1;
      reset = 1'b0;
      check_output(v.name, {sensor_up, sensor_down, sensor_door, car_floor, fault}, v.exp);
   endtask

   task automatic run_half(input logic [1:0] e, input int c);
      eng_h = e;
      repeat (c) @(posedge clock);
      #1;
   endtask

   initial begin
      //                name            rst   eng    door   cyc   up dn door   fl   flt
      vecs.push_back(mk("reset",         1, 2'b00, 2'b00,    2,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("up_pre_step",   0, 2'b01, 2'b00,   63,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("up_first_step", 0, 2'b01, 2'b00,    1,  0, 0, 2'b10, 4'd0, 0));
      vecs.push_back(mk("up_1023",       0, 2'b01, 2'b00,  959,  0, 0, 2'b10, 4'd0, 0));
      vecs.push_back(mk("up_arrive",     0, 2'b01, 2'b00,    1,  1, 0, 2'b10, 4'd1, 0));
      vecs.push_back(mk("up_hold",       0, 2'b00, 2'b00,   10,  1, 0, 2'b10, 4'd1, 0));
      vecs.push_back(mk("open_pre",      0, 2'b00, 2'b01,   63,  1, 0, 2'b10, 4'd1, 0));
      vecs.push_back(mk("open_first",    0, 2'b00, 2'b01,    1,  1, 0, 2'b00, 4'd1, 0));
      vecs.push_back(mk("open_31",       0, 2'b00, 2'b01, 1983,  1, 0, 2'b00, 4'd1, 0));
      vecs.push_back(mk("open_full",     0, 2'b00, 2'b01,    1,  1, 0, 2'b01, 4'd1, 0));
      vecs.push_back(mk("open_sat",      0, 2'b00, 2'b01,  100,  1, 0, 2'b01, 4'd1, 0));
      vecs.push_back(mk("move_door_opn", 0, 2'b01, 2'b00,    1,  1, 0, 2'b01, 4'd1, 1));
      vecs.push_back(mk("reset_motion",  1, 2'b01, 2'b01,    1,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("no_residual",   0, 2'b00, 2'b00,  100,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("eng_illegal",   0, 2'b11, 2'b00,    1,  0, 1, 2'b10, 4'd0, 1));
      vecs.push_back(mk("eng_ill_hold",  0, 2'b11, 2'b00,  100,  0, 1, 2'b10, 4'd0, 1));
      vecs.push_back(mk("reset_clr1",    1, 2'b00, 2'b00,    1,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("door_illegal",  0, 2'b00, 2'b11,    1,  0, 1, 2'b10, 4'd0, 1));
      vecs.push_back(mk("reset_clr2",    1, 2'b00, 2'b00,    1,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("down_pre",      0, 2'b10, 2'b00,   63,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("down_overtrav", 0, 2'b10, 2'b00,    1,  0, 1, 2'b10, 4'd0, 1));
      vecs.push_back(mk("reset_clr3",    1, 2'b00, 2'b00,    1,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("up_off1",       0, 2'b01, 2'b00,   64,  0, 0, 2'b10, 4'd0, 0));
      vecs.push_back(mk("door_mid_flr",  0, 2'b00, 2'b01,  100,  0, 0, 2'b10, 4'd0, 1));
      vecs.push_back(mk("reset_clr4",    1, 2'b00, 2'b00,    1,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("open_again",    0, 2'b00, 2'b01, 2048,  0, 1, 2'b01, 4'd0, 0));
      vecs.push_back(mk("close_first",   0, 2'b00, 2'b10,   64,  0, 1, 2'b00, 4'd0, 0));
      vecs.push_back(mk("close_31",      0, 2'b00, 2'b10, 1983,  0, 1, 2'b00, 4'd0, 0));
      vecs.push_back(mk("close_full",    0, 2'b00, 2'b10,    1,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("up_floor1",     0, 2'b01, 2'b00, 1024,  1, 0, 2'b10, 4'd1, 0));
      vecs.push_back(mk("down_cross",    0, 2'b10, 2'b00,   64,  0, 0, 2'b10, 4'd0, 0));
      vecs.push_back(mk("down_arrive",   0, 2'b10, 2'b00,  960,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("down_limit",    0, 2'b10, 2'b00,   64,  0, 1, 2'b10, 4'd0, 1));
      vecs.push_back(mk("reset_clr5",    1, 2'b00, 2'b00,    1,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("presc_part",    0, 2'b01, 2'b00,   40,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("presc_stop",    0, 2'b00, 2'b00,    1,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("presc_restart", 0, 2'b01, 2'b00,   63,  0, 1, 2'b10, 4'd0, 0));
      vecs.push_back(mk("presc_step",    0, 2'b01, 2'b00,    1,  0, 0, 2'b10, 4'd0, 0));

      @(posedge clock);
      #1;
      foreach (vecs[i]) apply_stimulus(vecs[i]);

      // Half-floor start: arriving at floor 0 from offset 8, then running into the bottom limit.
      engine = 2'b00;
      door   = 2'b00;
      reset  = 1'b1;
      run_half(2'b00, 1);
      reset  = 1'b0;
      check_output("half_reset", {up_h, down_h, sdoor_h, floor_h, fault_h}, {1'b0, 1'b0, 2'b10, 4'd0, 1'b0});
      run_half(2'b10, 511);
      check_output("half_pre_arrive", {up_h, down_h, sdoor_h, floor_h, fault_h}, {1'b0, 1'b0, 2'b10, 4'd0, 1'b0});
      run_half(2'b10, 1);
      check_output("half_arrive", {up_h, down_h, sdoor_h, floor_h, fault_h}, {1'b0, 1'b1, 2'b10, 4'd0, 1'b0});
      run_half(2'b10, 64);
      check_output("half_overtravel", {up_h, down_h, sdoor_h, floor_h, fault_h}, {1'b0, 1'b1, 2'b10, 4'd0, 1'b1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
